// File: rtl/uart_autobaud.sv
// uart_autobaud -- UART baud-rate detector.
//
// Waits for the serial line to sit idle (256 synchronized-high cycles), then
// times the four intervals between the five falling edges of a 0x55 sync
// character. The averaged bit period P selects a standard baud index.
//
// Ports:
//   clk        system clock (100 MHz), all state on the rising edge
//   rst_n      asynchronous active-low reset
//   Rx         asynchronous serial line, idle high
//   Relearn    single-cycle request to drop the lock and re-measure
//   Busy       high while a measurement is in progress
//   Lock       high while BR_Select/BR_Clocks hold a detected rate
//   Err        one-cycle pulse on a failed measurement
//   BR_Select  detected baud index (0=4800 ... 7=230400)
//   BR_Clocks  clocks per bit for the detected rate
//
// Build option: define UART_AUTOBAUD_SNAP_EN to report the standard table
// clocks-per-bit for BR_Select instead of the measured period.

module uart_autobaud (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Rx,
    input  logic        Relearn,
    output logic        Busy,
    output logic        Lock,
    output logic        Err,
    output logic [2:0]  BR_Select,
    output logic [14:0] BR_Clocks
);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, LOCKED} state_t;

    state_t             state;
    logic               rx_p0, rx_p1, rx_prev;
    logic [7:0]         idle_cnt;
    logic [15:0]        ival_cnt;
    logic [2:0]         edge_cnt;
    logic [15:0]        i0;
    logic [17:0]        span;

    logic               fall;
    logic [15:0]        ival;
    logic signed [17:0] ival_diff;
    logic               in_tol;
    logic [18:0]        span_sum;
    logic [14:0]        p_new;
    logic               meas_fail;
    logic               meas_lock;

    function automatic logic [17:0] abs_diff(input logic signed [17:0] d);
        return (d < 0) ? 18'(-d) : 18'(d);
    endfunction

    function automatic logic [2:0] sel_of(input logic [14:0] p);
        if (p >= 15'd15626)     return 3'd0;
        else if (p >= 15'd8681) return 3'd1;
        else if (p >= 15'd6077) return 3'd2;
        else if (p >= 15'd3906) return 3'd3;
        else if (p >= 15'd2170) return 3'd4;
        else if (p >= 15'd1302) return 3'd5;
        else if (p >= 15'd651)  return 3'd6;
        else                    return 3'd7;
    endfunction

`ifdef UART_AUTOBAUD_SNAP_EN
    function automatic logic [14:0] snap_of(input logic [2:0] sel);
        case (sel)
            3'd0:    return 15'd20834;
            3'd1:    return 15'd10417;
            3'd2:    return 15'd6945;
            3'd3:    return 15'd5208;
            3'd4:    return 15'd2604;
            3'd5:    return 15'd1736;
            3'd6:    return 15'd868;
            default: return 15'd434;
        endcase
    endfunction
`endif

    // The counter restarts at 0 on the cycle after an edge, so the edge-to-edge
    // distance is the count plus one.
    assign fall      = ~rx_p1 & rx_prev;
    assign ival      = ival_cnt + 16'd1;
    assign ival_diff = $signed({2'b00, ival}) - $signed({2'b00, i0});
    assign in_tol    = abs_diff(ival_diff) < {4'b0000, i0[15:2]};
    assign span_sum  = {1'b0, span} + {3'b000, ival};
    assign p_new     = 15'((span_sum + 19'd4) >> 3);

    // Relearn outranks every measurement outcome, including a valid fifth edge.
    always_comb begin
        meas_fail = 1'b0;
        meas_lock = 1'b0;
        if (state == MEASURE && !Relearn) begin
            if (ival_cnt == 16'hFFFF) begin
                meas_fail = 1'b1;
            end else if (fall && edge_cnt != 3'd1) begin
                if (!in_tol)
                    meas_fail = 1'b1;
                else if (edge_cnt == 3'd4) begin
                    if (p_new < 15'd217)
                        meas_fail = 1'b1;
                    else
                        meas_lock = 1'b1;
                end
            end
        end
    end

    // Synchronizer stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0   <= 1'b1;
            rx_p1   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_p0   <= Rx;
            rx_p1   <= rx_p0;
            rx_prev <= rx_p1;
        end
    end

    // Control and measurement stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idle_cnt  <= 8'd0;
            ival_cnt  <= 16'd0;
            edge_cnt  <= 3'd0;
            i0        <= 16'd0;
            span      <= 18'd0;
            Busy      <= 1'b0;
            Lock      <= 1'b0;
            Err       <= 1'b0;
            BR_Select <= 3'd1;
            BR_Clocks <= 15'd10417;
        end else begin
            Err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_p1)
                        idle_cnt <= 8'd0;
                    else if (idle_cnt == 8'hFF) begin
                        idle_cnt <= 8'd0;
                        state    <= ARMED;
                    end else
                        idle_cnt <= idle_cnt + 8'd1;
                end
                ARMED: begin
                    if (fall) begin
                        state    <= MEASURE;
                        ival_cnt <= 16'd0;
                        edge_cnt <= 3'd1;
                        Busy     <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (Relearn || meas_fail) begin
                        state    <= IDLE;
                        idle_cnt <= 8'd0;
                        Busy     <= 1'b0;
                        Err      <= meas_fail;
                    end else if (meas_lock) begin
                        state     <= LOCKED;
                        Busy      <= 1'b0;
                        Lock      <= 1'b1;
                        BR_Select <= sel_of(p_new);
`ifdef UART_AUTOBAUD_SNAP_EN
                        BR_Clocks <= snap_of(sel_of(p_new));
`else
                        BR_Clocks <= p_new;
`endif
                    end else if (fall) begin
                        if (edge_cnt == 3'd1) begin
                            i0   <= ival;
                            span <= {2'b00, ival};
                        end else
                            span <= span_sum[17:0];
                        edge_cnt <= edge_cnt + 3'd1;
                        ival_cnt <= 16'd0;
                    end else
                        ival_cnt <= ival_cnt + 16'd1;
                end
                LOCKED: begin
                    if (Relearn) begin
                        state    <= IDLE;
                        idle_cnt <= 8'd0;
                        Lock     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
